md_sched: RTL and testbench
===========================

MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 op_valid  in  1  pipeline presents a HI/LO-class op this cycle.
REQ-004 op_type  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mflo, 6 mfhi, 7 mtlo, 8 mthi; other codes are no-ops.
REQ-005 op_a, op_b  in  32 each  operands; mt ops use op_a only.
REQ-006 op_ready  out  1  op accepted at the clock edge when op_valid&&op_ready.
REQ-007 flush  in  1  exception/interrupt flush; discards queued, not-yet-issued ops.
REQ-008 md_start  out  1  one-cycle issue pulse to the external multiply/divide unit.
REQ-009 md_func  out  2  0 mult, 1 multu, 2 div, 3 divu; valid while md_start=1.
REQ-010 md_a, md_b  out  32 each  operands to the unit; valid while md_start=1.
REQ-011 md_done  in  1  one-cycle completion pulse from the unit.
REQ-012 md_hi, md_lo  in  32 each  results; valid while md_done=1.
REQ-013 rd_data  out  32  mflo/mfhi read data.
REQ-014 mf_stall  out  1  mf read must stall this cycle.
REQ-015 busy  out  1  ops pending or in flight.

Function
REQ-016 Internal state: 2-entry in-order FIFO of {type, a, b}, count 0..2; FSM states IDLE, BUSY; architectural hi, lo registers.
REQ-017 Ops 1-4 and 7-8 enqueue when op_valid&&op_ready&&!flush; ops 5-6 and illegal codes never enqueue.
REQ-018 op_ready = (count<2) for enqueueable types; = !mf_stall for types 5-6; = 1 for illegal codes.
REQ-019 No enqueue when count=2, even if a pop occurs that same cycle.
REQ-020 IDLE, head is 7/8: lo (7) or hi (8) <= head.a at the edge; pop; remain IDLE.
REQ-021 IDLE, head is 1-4: md_start=1 combinationally with md_func=type-1, md_a/md_b=head operands; pop; go BUSY at the edge.
REQ-022 Enqueue into an empty FIFO while IDLE is issued the following cycle (1-cycle issue latency); no same-cycle bypass.
REQ-023 BUSY: md_start=0; on md_done, hi<=md_hi, lo<=md_lo, go IDLE; the next head may issue in the cycle after.
REQ-024 md_done while IDLE is ignored.
REQ-025 busy = (count!=0) || (state==BUSY).
REQ-026 mf_stall = op_valid && op_type in {5,6} && busy.
REQ-027 rd_data = lo for type 5, hi for type 6, else 0; combinational from the architectural registers.
REQ-028 flush: count<=0 at the edge; a head popped that same cycle (mt write or md_start) still takes effect; an op already in BUSY completes and commits.
REQ-029 flush and op_valid in the same cycle: flush wins and the op is dropped.
REQ-030 FIFO pointers wrap modulo 2; order is strictly preserved between mt and mul/div ops.

Reset
REQ-031 reset: state IDLE, count 0, pointers 0, hi=0, lo=0.
REQ-032 After reset, busy=0, md_start=0, mf_stall=0, rd_data=0.
REQ-033 reset takes priority over all inputs; reset during BUSY abandons the op, and a later md_done while IDLE is ignored.

Verification
REQ-034 mthi 0x1234 accepted at edge N, mfhi presented in cycle N+1 -> mf_stall=1 in N+1; hi=0x1234 after edge N+1; rd_data=0x1234, mf_stall=0 in N+2.
REQ-035 mult a=-3, b=5 -> md_start one cycle with md_func=0; md_done with md_hi=0xFFFFFFFF, md_lo=0xFFFFFFF1 -> hi/lo commit; busy falls the next cycle.
REQ-036 divu in BUSY, then mtlo 7 and mult queued -> op_ready=0 at count 2; after md_done: lo=7, then md_start for the mult, in that order.
REQ-037 two ops queued behind a BUSY div, flush asserted -> count=0; div completes and commits; no further md_start.
REQ-038 reset asserted during BUSY, then md_done pulsed -> hi=lo=0, state IDLE, no commit.
REQ-039 op_type 0 and 12 with op_valid -> op_ready=1, count unchanged, no md_start.

Source files
------------

// File: rtl/md_sched.sv
// HI/LO operation scheduler: a 2-entry in-order queue that feeds an external
// multiply/divide unit and holds the architectural hi/lo registers.
module md_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op_type,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    input  logic        flush,
    output logic        md_start,
    output logic [1:0]  md_func,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_done,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic [31:0] rd_data,
    output logic        mf_stall,
    output logic        busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_reg;
    logic [3:0]  type_mem [2];
    logic [31:0] a_mem [2];
    logic [31:0] b_mem [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        op_is_md;
    logic        op_is_mt;
    logic        op_is_mf;
    logic        op_is_enq;
    logic        enq;
    logic        pop;
    logic [3:0]  head_type;
    logic [31:0] head_a;
    logic        head_is_md;

    always_comb begin
        op_is_md  = (op_type >= 4'd1) && (op_type <= 4'd4);
        op_is_mt  = (op_type == 4'd7) || (op_type == 4'd8);
        op_is_mf  = (op_type == 4'd5) || (op_type == 4'd6);
        op_is_enq = op_is_md || op_is_mt;
    end

    assign busy     = (count_reg != 2'd0) || (state_reg == BUSY);
    assign mf_stall = op_valid && op_is_mf && busy;

    // A full queue refuses new work even when its head drains this cycle.
    always_comb begin
        if (op_is_enq)
            op_ready = (count_reg != 2'd2);
        else if (op_is_mf)
            op_ready = !mf_stall;
        else
            op_ready = 1'b1;
    end

    assign enq = op_valid && op_ready && !flush && op_is_enq;

    assign head_type  = type_mem[rd_ptr_reg];
    assign head_a     = a_mem[rd_ptr_reg];
    assign head_is_md = (head_type >= 4'd1) && (head_type <= 4'd4);

    // Only enqueueable types are ever stored, so any head is poppable when idle.
    assign pop      = (state_reg == IDLE) && (count_reg != 2'd0);
    assign md_start = pop && head_is_md;
    assign md_func  = head_type[1:0] - 2'd1;
    assign md_a     = head_a;
    assign md_b     = b_mem[rd_ptr_reg];

    always_comb begin
        case (op_type)
            4'd5:    rd_data = lo_reg;
            4'd6:    rd_data = hi_reg;
            default: rd_data = 32'd0;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (enq && !pop)
            count_next = count_reg + 2'd1;
        else if (pop && !enq)
            count_next = count_reg - 2'd1;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (enq && (wr_ptr_reg == 1'(gi))) begin
                    type_mem[gi] <= op_type;
                    a_mem[gi]    <= op_a;
                    b_mem[gi]    <= op_b;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
        end else begin
            if (flush) begin
                count_reg  <= 2'd0;
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
            end else begin
                count_reg <= count_next;
                if (enq)
                    wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)
                    rd_ptr_reg <= ~rd_ptr_reg;
            end

            // The popped head still executes when a flush lands in the same cycle.
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        if (head_type == 4'd7)
                            lo_reg <= head_a;
                        else if (head_type == 4'd8)
                            hi_reg <= head_a;
                        else
                            state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        hi_reg    <= md_hi;
                        lo_reg    <= md_lo;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Scenario bench for md_sched: expected issues go into a scoreboard queue when
// an op is driven and are matched by a monitor whenever md_start fires.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op_type = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        op_ready;
    logic        flush = 1'b0;
    logic        md_start;
    logic [1:0]  md_func;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_done = 1'b0;
    logic [31:0] md_hi = 32'd0;
    logic [31:0] md_lo = 32'd0;
    logic [31:0] rd_data;
    logic        mf_stall;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  func;
        logic [31:0] a;
        logic [31:0] b;
    } issue_t;

    issue_t exp_q[$];
    issue_t got_e;

    always #5 clk = ~clk;

    md_sched dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .flush(flush),
        .md_start(md_start), .md_func(md_func), .md_a(md_a), .md_b(md_b),
        .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo), .rd_data(rd_data),
        .mf_stall(mf_stall), .busy(busy)
    );

    // Every md_start must match the oldest expected issue, in order.
    always @(negedge clk) begin
        #2;
        if (md_start === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got func=%0d a=%h b=%h, required no issue",
                         md_func, md_a, md_b);
            end else begin
                got_e = exp_q.pop_front();
                if ({md_func, md_a, md_b} !== {got_e.func, got_e.a, got_e.b}) begin
                    n_fail++;
                    $display("FAIL issue_match: got func=%0d a=%h b=%h, required func=%0d a=%h b=%h",
                             md_func, md_a, md_b, got_e.func, got_e.a, got_e.b);
                end else begin
                    $display("issue func=%0d a=%h b=%h", md_func, md_a, md_b);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op_type  = t;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic idle();
        op_valid = 1'b0;
        op_type  = 4'd0;
    endtask

    task automatic push_issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        issue_t e;
        e.func = f;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(4'd6, 32'd0, 32'd0);
        tick(); tick(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL reset_md_start: got %b, required 0", md_start); end
        n_checks++; if (mf_stall !== 1'b0) begin n_fail++; $display("FAIL reset_mf_stall: got %b, required 0", mf_stall); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h, required 0", rd_data); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mf_ready: got %b, required 1", op_ready); end
        reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_mt_mf();
        drive(4'd8, 32'h1234, 32'd0); #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL mthi_ready: got %b, required 1", op_ready); end
        tick();
        drive(4'd6, 32'd0, 32'd0); #1;
        n_checks++; if (mf_stall !== 1'b1) begin n_fail++; $display("FAIL mfhi_stall: got %b, required 1", mf_stall); end
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL mfhi_ready_stalled: got %b, required 0", op_ready); end
        tick(); #1;
        n_checks++; if (mf_stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_unstall: got %b, required 0", mf_stall); end
        n_checks++; if (rd_data !== 32'h1234) begin n_fail++; $display("FAIL mfhi_data: got %h, required 00001234", rd_data); end
        drive(4'd7, 32'h5678, 32'd0);
        tick(); idle(); tick();
        op_type = 4'd5; #1;
        n_checks++; if (rd_data !== 32'h5678) begin n_fail++; $display("FAIL mtlo_data: got %h, required 00005678", rd_data); end
        op_type = 4'd6; #1;
        n_checks++; if (rd_data !== 32'h1234) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h, required 00001234", rd_data); end
        idle();
    endtask

    task automatic test_mult();
        drive(4'd1, 32'hFFFFFFFD, 32'd5);
        push_issue(2'd0, 32'hFFFFFFFD, 32'd5); #1;
        n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL mult_no_bypass: got %b, required 0", md_start); end
        tick(); idle(); #1;
        n_checks++; if (md_start !== 1'b1) begin n_fail++; $display("FAIL mult_start: got %b, required 1", md_start); end
        tick(); #1;
        n_checks++; if (md_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mult_in_busy: got start=%b busy=%b, required start=0 busy=1", md_start, busy); end
        md_done = 1'b1; md_hi = 32'hFFFFFFFF; md_lo = 32'hFFFFFFF1;
        tick(); md_done = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_fall: got %b, required 0", busy); end
        op_type = 4'd6; #1;
        n_checks++; if (rd_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h, required ffffffff", rd_data); end
        op_type = 4'd5; #1;
        n_checks++; if (rd_data !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo: got %h, required fffffff1", rd_data); end
        idle();
    endtask

    task automatic test_order();
        drive(4'd4, 32'd100, 32'd7);
        push_issue(2'd3, 32'd100, 32'd7);
        tick();
        drive(4'd7, 32'd7, 32'd0); #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL order_mtlo_ready: got %b, required 1", op_ready); end
        tick();
        drive(4'd1, 32'd2, 32'd3);
        push_issue(2'd0, 32'd2, 32'd3); #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL order_mult_ready: got %b, required 1", op_ready); end
        tick();
        drive(4'd7, 32'd9, 32'd0); #1;
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL order_full_ready: got %b, required 0", op_ready); end
        tick(); idle(); #1;
        n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL order_busy_hold: got %b, required 0", md_start); end
        md_done = 1'b1; md_hi = 32'd2; md_lo = 32'd14;
        tick(); md_done = 1'b0;
        drive(4'd8, 32'd0, 32'd0); #1;
        n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL order_full_pop_ready: got %b, required 0", op_ready); end
        idle(); op_type = 4'd5; #1;
        n_checks++; if (rd_data !== 32'd14) begin n_fail++; $display("FAIL order_div_lo: got %h, required 0000000e", rd_data); end
        n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL order_mt_first: got %b, required 0", md_start); end
        tick(); op_type = 4'd5; #1;
        n_checks++; if (rd_data !== 32'd7) begin n_fail++; $display("FAIL order_mtlo_lo: got %h, required 00000007", rd_data); end
        n_checks++; if (md_start !== 1'b1) begin n_fail++; $display("FAIL order_mult_start: got %b, required 1", md_start); end
        tick();
        md_done = 1'b1; md_hi = 32'd0; md_lo = 32'd6;
        tick(); md_done = 1'b0; op_type = 4'd5; #1;
        n_checks++; if (busy !== 1'b0 || rd_data !== 32'd6) begin n_fail++; $display("FAIL order_final: got busy=%b lo=%h, required busy=0 lo=00000006", busy, rd_data); end
        idle();
    endtask

    task automatic test_flush();
        drive(4'd3, 32'hFFFFFFEC, 32'd3);
        push_issue(2'd2, 32'hFFFFFFEC, 32'd3);
        tick(); idle(); tick();
        drive(4'd1, 32'd11, 32'd12); tick();
        drive(4'd8, 32'h55, 32'd0); tick();
        drive(4'd1, 32'd99, 32'd99); flush = 1'b1;
        tick(); flush = 1'b0; idle(); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_div_inflight: got %b, required 1", busy); end
        md_done = 1'b1; md_hi = 32'hFFFFFFFE; md_lo = 32'hFFFFFFFA;
        tick(); md_done = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_emptied: got %b, required 0", busy); end
        op_type = 4'd6; #1;
        n_checks++; if (rd_data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL flush_div_hi: got %h, required fffffffe", rd_data); end
        op_type = 4'd5; #1;
        n_checks++; if (rd_data !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL flush_div_lo: got %h, required fffffffa", rd_data); end
        idle();
        repeat (4) tick();
        #1;
        n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue: got %b, required 0", md_start); end
        drive(4'd8, 32'h77, 32'd0); tick();
        drive(4'd7, 32'h33, 32'd0); flush = 1'b1;
        tick(); flush = 1'b0; idle(); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_pop_busy: got %b, required 0", busy); end
        op_type = 4'd6; #1;
        n_checks++; if (rd_data !== 32'h77) begin n_fail++; $display("FAIL flush_pop_hi: got %h, required 00000077", rd_data); end
        op_type = 4'd5; #1;
        n_checks++; if (rd_data !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL flush_drop_lo: got %h, required fffffffa", rd_data); end
        idle();
    endtask

    task automatic test_reset_busy();
        drive(4'd1, 32'd4, 32'd5);
        push_issue(2'd0, 32'd4, 32'd5);
        tick(); idle(); tick(); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstb_busy: got %b, required 1", busy); end
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstb_idle: got %b, required 0", busy); end
        md_done = 1'b1; md_hi = 32'hDEAD; md_lo = 32'hBEEF;
        tick(); md_done = 1'b0; #1;
        n_checks++; if (busy !== 1'b0 || md_start !== 1'b0) begin n_fail++; $display("FAIL rstb_after_done: got busy=%b start=%b, required 0 0", busy, md_start); end
        op_type = 4'd6; #1;
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rstb_hi: got %h, required 0", rd_data); end
        op_type = 4'd5; #1;
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rstb_lo: got %h, required 0", rd_data); end
        idle();
    endtask

    task automatic test_illegal();
        drive(4'd0, 32'd1, 32'd2); #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL illegal0_ready: got %b, required 1", op_ready); end
        tick();
        drive(4'd12, 32'd3, 32'd4); #1;
        n_checks++; if (op_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL illegal12: got ready=%b busy=%b, required 1 0", op_ready, busy); end
        tick(); idle(); #1;
        n_checks++; if (busy !== 1'b0 || md_start !== 1'b0) begin n_fail++; $display("FAIL illegal_noop: got busy=%b start=%b, required 0 0", busy, md_start); end
    endtask

    task automatic test_back_to_back();
        drive(4'd1, 32'd6, 32'd7);
        push_issue(2'd0, 32'd6, 32'd7);
        tick();
        drive(4'd2, 32'hFFFFFFFF, 32'd2);
        push_issue(2'd1, 32'hFFFFFFFF, 32'd2); #1;
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b, required 1", op_ready); end
        tick(); idle(); #1;
        n_checks++; if (md_start !== 1'b0) begin n_fail++; $display("FAIL b2b_wait: got %b, required 0", md_start); end
        md_done = 1'b1; md_hi = 32'd0; md_lo = 32'd42;
        tick(); md_done = 1'b0; #1;
        n_checks++; if (md_start !== 1'b1 || md_func !== 2'd1) begin n_fail++; $display("FAIL b2b_second_start: got start=%b func=%0d, required 1 1", md_start, md_func); end
        tick();
        md_done = 1'b1; md_hi = 32'd1; md_lo = 32'hFFFFFFFE;
        tick(); md_done = 1'b0; op_type = 4'd5; #1;
        n_checks++; if (busy !== 1'b0 || rd_data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL b2b_final: got busy=%b lo=%h, required 0 fffffffe", busy, rd_data); end
        idle();
    endtask

    initial begin
        test_reset();
        test_mt_mf();
        test_mult();
        test_order();
        test_flush();
        test_reset_busy();
        test_illegal();
        test_back_to_back();
        tick(); tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL issue_missing: got %0d issues outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
